// File: rtl/block_data_memory.sv
// Block-organised backing memory behind the data cache. Each request moves one
// 32-bit block and keeps busywait high for a fixed LATENCY cycles. A one-cycle
// DONE phase follows, in which requests are ignored.
module block_data_memory #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned LATENCY = 5   // legal range 2..15
) (
  input  logic              clock,
  input  logic              reset,      // asynchronous, active-low
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              busywait
);

  localparam int unsigned Depth   = 2 ** ADDR_W;
  localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              wr_q, wr_d;
  logic [31:0]       readdata_q;
  logic              busy;
  logic              perform;

  logic [31:0] mem_q [Depth];

  // Next-state logic: capture the request in IDLE, count latency, one DONE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    busy    = 1'b0;
    perform = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (read || write) begin
          busy    = 1'b1;
          state_d = StAccess;
          cnt_d   = CntLoad;
          addr_d  = address;
          data_d  = writedata;
          wr_d    = write;           // write has priority over read
        end
      end
      StAccess: begin
        busy  = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          perform = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        // Requester still holds read/write here, so this cycle never accepts.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Mask with reset so a request seen while reset is held never raises busywait.
  assign busywait = busy & reset;
  assign readdata = readdata_q;

  // Control and capture registers; reset aborts any in-flight access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      data_q  <= 32'h0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
    end
  end

  // Read result register; only a completed read updates it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      readdata_q <= 32'h0;
    end else if (perform && !wr_q) begin
      readdata_q <= mem_q[addr_q];
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clock) begin
    if (perform && wr_q) begin
      mem_q[addr_q] <= data_q;
    end
  end

endmodule

// File: tb/tb_block_data_memory.sv
// Bench for block_data_memory: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_block_data_memory;

  localparam int unsigned AddrW = 6;
  localparam int unsigned Lat   = 5;

  logic             clock;
  logic             reset;
  logic             read;
  logic             write;
  logic [AddrW-1:0] address;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic             busywait;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  block_data_memory #(
    .ADDR_W (AddrW),
    .LATENCY(Lat)
  ) u_dut (
    .clock    (clock),
    .reset    (reset),
    .read     (read),
    .write    (write),
    .address  (address),
    .writedata(writedata),
    .readdata (readdata),
    .busywait (busywait)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a request accepted in cycle t completes in cycle t+Lat,
  // and the block is free again from cycle t+Lat+1.
  logic [31:0]      m_mem [64];
  logic [31:0]      m_rd;
  int               m_done = -1;
  logic             m_wr;
  logic [AddrW-1:0] m_addr;
  logic [31:0]      m_data;

  always @(negedge clock) begin
    logic exp_busy;
    if (!reset) begin
      m_done   = -1;
      m_rd     = 32'h0;
      exp_busy = 1'b0;
    end else begin
      if (cyc == m_done) begin
        if (m_wr) m_mem[m_addr] = m_data;
        else      m_rd = m_mem[m_addr];
      end
      if (cyc < m_done)       exp_busy = 1'b1;
      else if (cyc == m_done) exp_busy = 1'b0;
      else begin
        exp_busy = read | write;
        if (read | write) begin
          m_done = cyc + Lat;
          m_wr   = write;
          m_addr = address;
          m_data = writedata;
        end
      end
    end
    chk("model_busywait", {31'b0, busywait}, {31'b0, exp_busy});
    chk("model_readdata", readdata, m_rd);
  end

  // Waits for busywait to fall; returns the DONE cycle number.
  task automatic wait_done(output int t_done);
    bit seen = 0;
    t_done = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (!busywait) begin
        seen   = 1;
        t_done = cyc;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fails++;
      $display("FAIL wait_done: busywait still 1 after 40 cycles, expected 0");
    end
  endtask

  // Cache-like requester: drive at posedge+1, hold through DONE, then drop.
  task automatic access(input logic r, input logic w, input logic [AddrW-1:0] a,
                        input logic [31:0] d, output int t_req, output int t_done);
    read      = r;
    write     = w;
    address   = a;
    writedata = d;
    t_req     = cyc;
    wait_done(t_done);
    @(posedge clock);
    #1;
    read  = 1'b0;
    write = 1'b0;
  endtask

  initial begin
    int tq, td, tq2, td2;
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tq, tq2, td, td2;
    logic [31:0] d;
    reset     = 1'b0;
    read      = 1'b1;   // request while in reset must be ignored
    write     = 1'b0;
    address   = '0;
    writedata = 32'h0;
    #3;
    chk("reset_busywait", {31'b0, busywait}, 32'h0);
    chk("reset_readdata", readdata, 32'h0);
    @(posedge clock);
    #1;
    read  = 1'b0;
    reset = 1'b1;

    // Fill the whole array so every later read has a known expectation.
    for (int i = 0; i < 64; i++) begin
      if (i == 3)      d = 32'h1234_5678;
      else if (i == 5) d = 32'h0505_0505;
      else             d = $urandom;
      access(1'b0, 1'b1, 6'(i), d, tq, td);
    end
    access(1'b1, 1'b0, 6'd5, 32'h0, tq, td);
    chk("pre_reset_read5", readdata, 32'h0505_0505);

    // Reset mid-ACCESS of a write: aborted, readdata cleared at once.
    read      = 1'b0;
    write     = 1'b1;
    address   = 6'd3;
    writedata = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("abort_busywait", {31'b0, busywait}, 32'h0);
    chk("abort_readdata", readdata, 32'h0);
    write = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    access(1'b1, 1'b0, 6'd3, 32'h0, tq, td);
    chk("abort_read3", readdata, 32'h1234_5678);

    // Write then read: busy for Lat cycles each, data returned in DONE.
    access(1'b0, 1'b1, 6'd6, 32'h4433_2211, tq, td);
    chk("wr6_latency", 32'(td - tq), 32'(Lat));
    read    = 1'b1;
    address = 6'd6;
    tq      = cyc;
    #1;
    chk("rd6_busy_in_req_cycle", {31'b0, busywait}, 32'h1);
    wait_done(td);
    chk("rd6_latency", 32'(td - tq), 32'(Lat));
    chk("rd6_data_in_done", readdata, 32'h4433_2211);
    // read still high through DONE; the cycle after must be idle.
    @(posedge clock); #1;
    read = 1'b0;
    @(negedge clock);
    chk("done_hold_idle", {31'b0, busywait}, 32'h0);
    @(posedge clock); #1;

    // Inputs changing during ACCESS are ignored.
    write     = 1'b1;
    address   = 6'd6;
    writedata = 32'hCAFE_0006;
    @(posedge clock); #1;
    @(posedge clock); #1;
    address   = 6'd9;
    writedata = 32'hBAD0_0009;
    wait_done(td);
    @(posedge clock); #1;
    write = 1'b0;
    access(1'b1, 1'b0, 6'd6, 32'h0, tq, td);
    chk("chg_addr6", readdata, 32'hCAFE_0006);
    access(1'b1, 1'b0, 6'd9, 32'h0, tq, td);
    chk("chg_addr9_untouched", readdata, m_mem[9]);

    // Write-back then fill, back to back.
    access(1'b0, 1'b1, 6'h21, 32'hAABB_CCDD, tq, td);
    access(1'b1, 1'b0, 6'h05, 32'h0, tq2, td2);
    chk("wb_fill_elapsed", 32'(td2 - tq + 1), 32'd12);
    chk("wb_fill_data", readdata, 32'h0505_0505);

    // Simultaneous read+write: write wins, readdata untouched.
    access(1'b1, 1'b1, 6'd2, 32'h0000_FFFF, tq, td);
    chk("rw_latency", 32'(td - tq), 32'(Lat));
    chk("rw_readdata_kept", readdata, 32'h0505_0505);
    access(1'b1, 1'b0, 6'h21, 32'h0, tq, td);
    chk("wb_addr21", readdata, 32'hAABB_CCDD);
    access(1'b1, 1'b0, 6'd2, 32'h0, tq, td);
    chk("rw_addr2", readdata, 32'h0000_FFFF);

    // Random traffic against the model.
    for (int i = 0; i < 80; i++) begin
      int unsigned op;
      op = $urandom_range(0, 3);
      case (op)
        0: access(1'b1, 1'b0, 6'($urandom), 32'h0, tq, td);
        1: access(1'b0, 1'b1, 6'($urandom), $urandom, tq, td);
        2: access(1'b1, 1'b1, 6'($urandom), $urandom, tq, td);
        default: begin
          repeat ($urandom_range(1, 3)) begin
            @(posedge clock); #1;
          end
        end
      endcase
    end

    @(posedge clock); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
